// File: rtl/tile_blitter.sv
// tile_blitter: copies one TILE_W x TILE_H tile from tile ROM into the
// 640x480 16-bit frame-buffer bRAM (port A), one pixel per clock.
// Supports signed placement with screen clipping, colour-key transparency,
// horizontal flip and a ROM read latency of ROM_LAT cycles.
//
// Ports:
//   clk        system clock (100 MHz)
//   RSTN       asynchronous reset, active-low
//   start      one-cycle request, sampled only while idle
//   tile_base  ROM word address of tile pixel (0,0)
//   left/top   signed screen position of tile column 0 / row 0
//   key_en     skip pixels equal to KEY_COLOR
//   flip_x     mirror the tile horizontally
//   busy       high from the cycle after start until done
//   done       one-cycle completion pulse
//   rom_addr   tile ROM address (registered)
//   rom_data   tile ROM data, valid ROM_LAT cycles after rom_addr
//   dst_addr   frame-buffer address
//   dst_data   frame-buffer write data
//   dst_wr     frame-buffer write enable
module tile_blitter #(
  parameter int          TILE_W    = 32,
  parameter int          TILE_H    = 32,
  parameter int          SCR_W     = 640,
  parameter int          SCR_H     = 480,
  parameter int          ROM_AW    = 16,
  parameter int          ROM_LAT   = 1,
  parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              start,
  input  logic [ROM_AW-1:0] tile_base,
  input  logic [10:0]       left,
  input  logic [10:0]       top,
  input  logic              key_en,
  input  logic              flip_x,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [18:0]       dst_addr,
  output logic [15:0]       dst_data,
  output logic              dst_wr
);

  localparam int          CW  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int          RW  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int unsigned NST = ROM_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // One issued pixel: x/y are 12-bit two's complement screen coordinates.
  typedef struct packed {
    logic        v;
    logic [11:0] x;
    logic [11:0] y;
  } stage_t;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] base_q;
  logic [10:0]       left_q, top_q;
  logic              key_q, flip_q;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ROM_AW-1:0] rom_addr_q;
  stage_t            pipe_q [NST];
  logic [18:0]       dst_addr_q;
  logic [15:0]       dst_data_q;
  logic              dst_wr_q;

  // Issue-side sources: while idle the raw inputs feed the first issue,
  // afterwards the latched copies are used.
  logic [ROM_AW-1:0] base_n;
  logic [10:0]       left_n, top_n;
  logic              flip_n;
  logic              issue;
  logic [CW-1:0]     c_n;
  logic [ROM_AW-1:0] addr_n;
  logic [11:0]       x_n, y_n;
  logic              any_vld;

  // Data-stage signals
  logic [11:0] xd, yd;
  logic        in_x, in_y, keyed, wr_n;
  logic [18:0] addr_w;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    issue   = 1'b0;
    if (state_q == S_IDLE) begin
      base_n = tile_base;
      left_n = left;
      top_n  = top;
      flip_n = flip_x;
    end else begin
      base_n = base_q;
      left_n = left_q;
      top_n  = top_q;
      flip_n = flip_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          issue   = 1'b1;
        end
      end
      S_RUN: begin
        // row_d/col_d name the pixel issued on the next clock edge.
        if (col_q == CW'(TILE_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(TILE_H - 1)) begin
            state_d = S_DRAIN;
          end else begin
            row_d = row_q + RW'(1);
            issue = 1'b1;
          end
        end else begin
          col_d = col_q + CW'(1);
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!any_vld) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    c_n    = flip_n ? (CW'(TILE_W - 1) - col_d) : col_d;
    addr_n = base_n + ROM_AW'(row_d) * ROM_AW'(TILE_W) + ROM_AW'(c_n);
    // Screen position uses the un-flipped column so a flipped tile covers
    // the same rectangle.
    x_n    = {left_n[10], left_n} + 12'(col_d);
    y_n    = {top_n[10], top_n} + 12'(row_d);
  end

  always_comb begin
    any_vld = 1'b0;
    for (int unsigned i = 0; i < NST; i++) any_vld = any_vld | pipe_q[i].v;
  end

  always_comb begin
    xd     = pipe_q[NST-1].x;
    yd     = pipe_q[NST-1].y;
    in_x   = !xd[11] && (xd < 12'(SCR_W));
    in_y   = !yd[11] && (yd < 12'(SCR_H));
    keyed  = key_q && (rom_data == KEY_COLOR);
    wr_n   = pipe_q[NST-1].v && in_x && in_y && !keyed;
    addr_w = 19'(yd) * 19'(SCR_W) + 19'(xd);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      left_q     <= '0;
      top_q      <= '0;
      key_q      <= 1'b0;
      flip_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      rom_addr_q <= '0;
      for (int unsigned i = 0; i < NST; i++) pipe_q[i] <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_wr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (state_q == S_IDLE && start) begin
        base_q <= tile_base;
        left_q <= left;
        top_q  <= top;
        key_q  <= key_en;
        flip_q <= flip_x;
      end
      if (issue) rom_addr_q <= addr_n;
      pipe_q[0] <= '{v: issue, x: x_n, y: y_n};
      for (int unsigned i = 1; i < NST; i++) pipe_q[i] <= pipe_q[i-1];
      dst_wr_q <= wr_n;
      if (wr_n) begin
        dst_addr_q <= addr_w;
        dst_data_q <= rom_data;
      end
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign rom_addr = rom_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_wr   = dst_wr_q;

endmodule

// File: tb/tb_tile_blitter.sv
// Directed bench for tile_blitter: a ROM_LAT=1 instance carries most checks,
// a ROM_LAT=3 instance shares the stimulus for latency checks.
module tb_tile_blitter;

  logic        clk = 1'b0;
  logic        RSTN, start, key_en, flip_x;
  logic [15:0] tile_base;
  logic [10:0] left, top;

  logic        busy, done, dst_wr;
  logic [15:0] rom_addr, rom_data, dst_data;
  logic [18:0] dst_addr;

  logic        busy3, done3, dst_wr3;
  logic [15:0] rom_addr3, rom_data3, dst_data3;
  logic [18:0] dst_addr3;

  logic        key_mode = 1'b0;
  int          cyc = 0;
  int          gen = 0;
  int          t0 = 0;
  int          ncmp = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  tile_blitter #(.ROM_LAT(1)) dut (
    .clk(clk), .RSTN(RSTN), .start(start), .tile_base(tile_base),
    .left(left), .top(top), .key_en(key_en), .flip_x(flip_x),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_wr(dst_wr)
  );

  tile_blitter #(.ROM_LAT(3)) dut3 (
    .clk(clk), .RSTN(RSTN), .start(start), .tile_base(tile_base),
    .left(left), .top(top), .key_en(key_en), .flip_x(flip_x),
    .busy(busy3), .done(done3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .dst_addr(dst_addr3), .dst_data(dst_data3), .dst_wr(dst_wr3)
  );

  // ROM contents: word i holds i, or KEY_COLOR on even words in key mode.
  function automatic logic [15:0] romf(input logic [15:0] a);
    if (key_mode && !a[0]) return 16'hF81F;
    return a;
  endfunction

  logic [15:0] r3a, r3b;
  always @(posedge clk) begin
    rom_data  <= romf(rom_addr);
    r3a       <= romf(rom_addr3);
    r3b       <= r3a;
    rom_data3 <= r3b;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-run statistics, cleared whenever gen changes.
  int sg = -1;
  int cnt, fa, fd, la, ld, maxc, maxr, d31, evn, dn, dcyc;
  int cnt3, la3, dn3, dcyc3;
  always @(negedge clk) begin
    if (sg != gen) begin
      sg <= gen; cnt <= 0; fa <= -1; fd <= -1; la <= -1; ld <= -1;
      maxc <= 0; maxr <= 0; d31 <= -1; evn <= 0; dn <= 0; dcyc <= -1;
      cnt3 <= 0; la3 <= -1; dn3 <= 0; dcyc3 <= -1;
    end else begin
      if (dst_wr) begin
        if (cnt == 0) begin
          fa <= int'(dst_addr);
          fd <= int'(dst_data);
        end
        la  <= int'(dst_addr);
        ld  <= int'(dst_data);
        cnt <= cnt + 1;
        if (int'(dst_addr) % 640 > maxc) maxc <= int'(dst_addr) % 640;
        if (int'(dst_addr) / 640 > maxr) maxr <= int'(dst_addr) / 640;
        if (dst_addr == 19'd31) d31 <= int'(dst_data);
        if (!dst_data[0]) evn <= evn + 1;
      end
      if (done) begin
        dn   <= dn + 1;
        dcyc <= cyc - t0;
      end
      if (dst_wr3) begin
        cnt3 <= cnt3 + 1;
        la3  <= int'(dst_addr3);
      end
      if (done3) begin
        dn3   <= dn3 + 1;
        dcyc3 <= cyc - t0;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ends on the negedge inside cycle 0 (first RUN cycle).
  task automatic launch(input int l, input int t, input logic ke,
                        input logic fx, input logic km);
    @(negedge clk);
    left = 11'(l); top = 11'(t); key_en = ke; flip_x = fx; key_mode = km;
    gen++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk("busy_cycle0", int'(busy), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1300 && !(dn > 0 && dn3 > 0); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    #2;
    chk("done_seen", int'(dn > 0 && dn3 > 0), 1);
    chk("idle_after", int'(busy), 0);
  endtask

  initial begin
    RSTN = 1'b0; start = 1'b0; tile_base = '0; left = '0; top = '0;
    key_en = 1'b0; flip_x = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr", int'(dst_wr), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_dst_addr", int'(dst_addr), 0);
    chk("rst_dst_data", int'(dst_data), 0);
    chk("rst_busy3", int'(busy3), 0);
    @(negedge clk);
    RSTN = 1'b1;

    // On-screen tile, ROM[i] = i
    launch(100, 50, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t1_count", cnt, 1024);
    chk("t1_first_addr", fa, 32100);
    chk("t1_first_data", fd, 0);
    chk("t1_last_addr", la, 51971);
    chk("t1_last_data", ld, 1023);
    chk("t1_done_cycle", dcyc, 1026);
    chk("t1_done_pulses", dn, 1);
    chk("lat3_done_cycle", dcyc3, 1028);
    chk("lat3_count", cnt3, 1024);
    chk("lat3_last_addr", la3, 51971);

    // Left clip
    launch(-4, 0, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t2_count", cnt, 896);
    chk("t2_first_addr", fa, 0);
    chk("t2_first_data", fd, 4);
    chk("t2_max_col", maxc, 27);
    chk("t2_max_row", maxr, 31);
    chk("t2_last_addr", la, 19867);
    chk("t2_last_data", ld, 1023);

    // Bottom-right clip
    launch(620, 470, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t3_count", cnt, 200);
    chk("t3_first_addr", fa, 301420);
    chk("t3_last_addr", la, 307199);
    chk("t3_last_data", ld, 307);

    // Fully off-screen
    launch(700, 0, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t4_count", cnt, 0);
    chk("t4_done_cycle", dcyc, 1026);
    chk("t4_done_pulses", dn, 1);

    // Colour key on / off
    launch(0, 0, 1'b1, 1'b0, 1'b1);
    wait_done();
    chk("t5_key_count", cnt, 512);
    chk("t5_key_even_data", evn, 0);
    chk("t5_key_first_addr", fa, 1);
    chk("t5_key_first_data", fd, 1);
    launch(0, 0, 1'b0, 1'b0, 1'b1);
    wait_done();
    chk("t5_nokey_count", cnt, 1024);
    chk("t5_nokey_first_data", fd, 63519);

    // Horizontal flip
    launch(0, 0, 1'b0, 1'b1, 1'b0);
    wait_done();
    chk("t6_count", cnt, 1024);
    chk("t6_first_addr", fa, 0);
    chk("t6_first_data", fd, 31);
    chk("t6_data_at_31", d31, 0);
    chk("t6_last_addr", la, 19871);
    chk("t6_last_data", ld, 992);

    // start pulsed mid-run must be ignored
    launch(100, 50, 1'b0, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    left = 11'd0; top = 11'd0; flip_x = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("t7_count", cnt, 1024);
    chk("t7_done_pulses", dn, 1);
    chk("t7_last_addr", la, 51971);
    chk("t7_done_cycle", dcyc, 1026);
    chk("t7_done_pulses3", dn3, 1);

    // Reset mid-operation
    launch(100, 50, 1'b0, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    RSTN = 1'b0;
    #1;
    chk("t8_rst_wr", int'(dst_wr), 0);
    chk("t8_rst_busy", int'(busy), 0);
    chk("t8_rst_wr3", int'(dst_wr3), 0);
    @(negedge clk);
    RSTN = 1'b1;
    gen++;
    repeat (10) @(negedge clk);
    #2;
    chk("t8_no_writes_after", cnt, 0);
    chk("t8_idle_after", int'(busy), 0);
    launch(100, 50, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("t8_restart_count", cnt, 1024);
    chk("t8_restart_first_addr", fa, 32100);
    chk("t8_restart_done_cycle", dcyc, 1026);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/tile_blitter.md
Name: tile_blitter

Overview:
- Parametrised successor to the single-pixel tile renderer: copies one TILE_W x TILE_H tile from tile ROM into the 640x480 16-bit frame-buffer bRAM, one pixel per clock.
- Adds start/busy/done handshake, signed positions with screen clipping, colour-key transparency, horizontal flip, and a configurable ROM read latency.
- Sits between game/render control logic and port A of the frame-buffer bRAM, in the 100 MHz clk domain.

Parameters:
- TILE_W, 32, tile width in pixels (power of 2).
- TILE_H, 32, tile height in pixels.
- SCR_W, 640, screen width; also the frame-buffer row stride.
- SCR_H, 480, screen height.
- ROM_AW, 16, tile ROM address width.
- ROM_LAT, 1, tile ROM read latency in cycles (1..3).
- KEY_COLOR, 16'hF81F, transparent colour value.

Ports:
- clk  in  1  system clock, 100 MHz
- RSTN  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- tile_base  in  ROM_AW  ROM word address of tile pixel (0,0)
- left  in  11  signed screen x of tile column 0
- top  in  11  signed screen y of tile row 0
- key_en  in  1  enable colour-key skip
- flip_x  in  1  mirror tile horizontally
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse on completion
- rom_addr  out  ROM_AW  tile ROM address
- rom_data  in  16  tile ROM data, valid ROM_LAT cycles after rom_addr
- dst_addr  out  19  frame-buffer address
- dst_data  out  16  frame-buffer write data
- dst_wr  out  1  frame-buffer write enable

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE; busy, done, dst_wr = 0; rom_addr, dst_addr, dst_data = 0; issue pipeline valid bits cleared.
- State IDLE:
  - start=1 latches tile_base, left, top, key_en and flip_x, clears row and col, and moves to RUN.
  - start is ignored in every other state; latched inputs stay fixed for the whole operation.
- State RUN:
  - Cycle k = 0..N-1, where N = TILE_W*TILE_H: rom_addr (registered) = tile_base + row*TILE_W + c.
  - c = col, or TILE_W-1-col when flip_x=1.
  - col increments every cycle; on col = TILE_W-1, col wraps to 0 and row increments.
  - After the last pixel (row = TILE_H-1, col = TILE_W-1), go to DRAIN.
  - ROM address arithmetic wraps modulo 2^ROM_AW.
- Pipeline:
  - A valid bit plus x = left+col and y = top+row (12-bit signed, no overflow) travel ROM_LAT stages alongside each issued address.
  - x and y use the un-flipped col, so a flipped tile occupies the same screen rectangle.
  - On the data stage, the block registers dst_wr = valid & (0 <= x < SCR_W) & (0 <= y < SCR_H) & !(key_en & rom_data == KEY_COLOR).
  - Same stage: dst_addr = y*SCR_W + x (19-bit); dst_data = rom_data.
  - Pixel k's write is visible in cycle k+ROM_LAT+1.
  - When dst_wr = 0, dst_addr and dst_data hold their previous values.
- State DRAIN: waits until all valid bits are clear, then moves to DONE.
- State DONE: done = 1 for exactly one cycle, busy = 0 in that same cycle, then IDLE.
  - Start-to-done is N+ROM_LAT+1 cycles, where cycle 0 is the first RUN cycle.
- Fully off-screen tile: the full sweep still runs, no writes occur, and done timing is unchanged.
- Reset mid-operation:
  - Everything aborts immediately; in-flight pixels are discarded and no write follows the reset release.
  - The next start behaves normally.

Test Plan:
- ROM[i] = i, tile_base = 0, left = 100, top = 50, ROM_LAT = 1 -> 1024 writes.
  - First write: dst_addr = 32100, data 0.
  - Last write: dst_addr = 81*640+131 = 51971, data 1023.
  - done in cycle 1026.
- left = -4, top = 0 -> 896 writes, 28 per row.
  - First write: dst_addr = 0, data 4.
  - No dst_addr ever exceeds row bounds.
- left = 620, top = 470 -> 200 writes (20x10).
  - Last write: dst_addr = 307199.
  - left = 700 -> 0 writes, done still in cycle 1026.
- Even ROM words = KEY_COLOR, key_en = 1 -> 512 writes, all odd addresses' data.
  - Same stimulus with key_en = 0 -> 1024 writes.
- flip_x = 1, left = 0, top = 0 -> first write: dst_addr 0, data 31.
  - Write at dst_addr 31 carries data 0.
- Handshake, reset and latency:
  - start pulsed mid-run -> ignored; exactly 1024 writes and a single done pulse.
  - RSTN low at pixel 300 -> dst_wr and busy 0 immediately; a fresh start afterwards completes normally.
  - ROM_LAT = 3 build -> done in cycle 1028.
